// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles SOF/ADDR/DATA/CHK frames from UART RX bytes into R/G/B duty registers.
// Optional ack handshake port set enabled by defining PARSER_ACK_EN.
module uart_cmd_parser #(
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] SOF_BYTE       = 8'hA5,
    parameter int                    TIMEOUT_CYCLES = 50000,
    parameter logic [DATA_WIDTH-1:0] DUTY_RESET     = '0
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  rx_done,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic [DATA_WIDTH-1:0] duty_r,
    output logic [DATA_WIDTH-1:0] duty_g,
    output logic [DATA_WIDTH-1:0] duty_b,
    output logic                  cfg_valid,
    output logic                  frame_err,
    output logic [7:0]            err_count
`ifdef PARSER_ACK_EN
    ,
    output logic                  ack_valid,
    output logic [7:0]            ack_data,
    input  logic                  ack_ready
`endif
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] GET_ADDR = 2'd1;
    localparam logic [1:0] GET_DATA = 2'd2;
    localparam logic [1:0] GET_CHK  = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_n;
    logic                  done_q;
    logic                  byte_stb;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [TW-1:0]         timer;
    logic                  timed_out;
    logic                  chk_ok;
    logic                  commit;
    logic                  reject;

    assign byte_stb  = rx_done & ~done_q;
    assign timed_out = (state != IDLE) && !byte_stb && (timer == TW'(TIMEOUT_CYCLES - 1));
    assign chk_ok    = (rx_data == (addr ^ data)) && (addr <= DATA_WIDTH'(3));

    always_comb begin
        state_n = state;
        commit  = 1'b0;
        reject  = 1'b0;
        if (byte_stb) begin
            case (state)
                IDLE:     state_n = (rx_data == SOF_BYTE) ? GET_ADDR : IDLE;
                GET_ADDR: state_n = GET_DATA;
                GET_DATA: state_n = GET_CHK;
                default: begin
                    state_n = IDLE;
                    commit  = chk_ok;
                    reject  = !chk_ok;
                end
            endcase
        end else if (timed_out) begin
            state_n = IDLE;
            reject  = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            done_q <= 1'b0;
            addr   <= '0;
            data   <= '0;
            timer  <= '0;
        end else begin
            state  <= state_n;
            done_q <= rx_done;
            timer  <= (state == IDLE || byte_stb || timed_out) ? '0 : timer + TW'(1);
            if (byte_stb && state == GET_ADDR)
                addr <= rx_data;
            if (byte_stb && state == GET_DATA)
                data <= rx_data;
        end
    end

    // Address 3 is a broadcast to all three channels.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_r    <= DUTY_RESET;
            duty_g    <= DUTY_RESET;
            duty_b    <= DUTY_RESET;
            cfg_valid <= 1'b0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            cfg_valid <= commit;
            frame_err <= reject;
            if (commit && (addr == DATA_WIDTH'(0) || addr == DATA_WIDTH'(3)))
                duty_r <= data;
            if (commit && (addr == DATA_WIDTH'(1) || addr == DATA_WIDTH'(3)))
                duty_g <= data;
            if (commit && (addr == DATA_WIDTH'(2) || addr == DATA_WIDTH'(3)))
                duty_b <= data;
            if (reject && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

`ifdef PARSER_ACK_EN
    // A fresh result overrides a pending one, even if it is being accepted this cycle.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_valid <= 1'b0;
            ack_data  <= 8'h00;
        end else if (commit || reject) begin
            ack_valid <= 1'b1;
            ack_data  <= commit ? 8'h06 : 8'h15;
        end else if (ack_ready) begin
            ack_valid <= 1'b0;
        end
    end
`endif
endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART RX PHY and consumes its received bytes (rx_done + 8-bit data).
- Assembles 4-byte command frames: SOF, ADDR, DATA, CHK.
- Checks each frame and, on success, updates the R/G/B duty-cycle registers that drive the PWM generators.
- Rejects malformed or stalled frames and counts them in an error counter.

Parameters:
- DATA_WIDTH, 8, width of the byte bus and of each duty register.
- SOF_BYTE, 8'hA5, start-of-frame marker.
- TIMEOUT_CYCLES, 50000, maximum sys_clk cycles allowed between consecutive bytes of one frame.
- DUTY_RESET, 0, reset value of every duty register.

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_done  in  1  byte-ready flag from the RX PHY; may stay high for many sys_clk cycles
- rx_data  in  DATA_WIDTH  received byte; stable while rx_done is high
- duty_r  out  DATA_WIDTH  red duty register
- duty_g  out  DATA_WIDTH  green duty register
- duty_b  out  DATA_WIDTH  blue duty register
- cfg_valid  out  1  one-cycle pulse when a duty update commits
- frame_err  out  1  one-cycle pulse on any rejected frame
- err_count  out  8  saturating count of rejected frames

Behaviour:
- Clock and reset: one clock, sys_clk. Reset rst_n is asynchronous and active-low.
- Reset values: duty_r/g/b = DUTY_RESET; cfg_valid = 0; frame_err = 0; err_count = 0; state = IDLE; timeout counter = 0.
- Byte strobe:
  - done_q is a register holding rx_done delayed by one cycle.
  - byte_stb = rx_done & ~done_q.
  - Exactly one strobe per byte, however long rx_done stays high.
  - rx_data is sampled in the cycle byte_stb is high.
- FSM states: IDLE, GET_ADDR, GET_DATA, GET_CHK.
  - IDLE: on byte_stb with rx_data == SOF_BYTE, go to GET_ADDR. Any other byte is silently ignored (no error).
  - GET_ADDR: on byte_stb, latch addr, go to GET_DATA.
  - GET_DATA: on byte_stb, latch data, go to GET_CHK.
  - GET_CHK: on byte_stb, always return to IDLE, then:
    - If rx_data == (addr ^ data) and addr <= 3: commit.
    - Otherwise: error.
- Commit, by addr:
  - 0 writes duty_r.
  - 1 writes duty_g.
  - 2 writes duty_b.
  - 3 writes all three with data.
  - Duty registers and cfg_valid are registered and visible 1 cycle after the clock edge where the CHK byte_stb is high.
  - cfg_valid is high for exactly that one cycle.
- Error:
  - frame_err pulses for 1 cycle, with the same timing as cfg_valid.
  - err_count increments and saturates at 255 (no wrap).
  - Duty registers are unchanged.
- Timeout:
  - The counter clears on every byte_stb and in IDLE.
  - It increments each cycle in GET_ADDR, GET_DATA and GET_CHK.
  - On reaching TIMEOUT_CYCLES-1 with no byte_stb: frame_err pulse, err_count increment, return to IDLE.
  - If byte_stb and the timeout fall in the same cycle, the byte wins and no timeout is raised.
- SOF inside a frame: SOF_BYTE received in GET_ADDR, GET_DATA or GET_CHK is treated as ordinary data. There is no resync; the checksum or timeout catches desync.
- Back-to-back frames: a new SOF may arrive on the very next byte_stb after a CHK; no idle gap is needed.
- Reset mid-frame: the partial frame is discarded and all outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro: PARSER_ACK_EN.
- With the macro defined:
  - Extra ports ack_valid (out, 1), ack_data (out, 8) and ack_ready (in, 1) form a valid/ready handshake.
  - On commit, ack_data = 8'h06; on error or timeout, ack_data = 8'h15. ack_valid rises in the same cycle as cfg_valid/frame_err.
  - ack_valid holds, with ack_data stable, until the cycle ack_ready is high.
  - If a new result arrives while an ack is still pending, the pending ack is overwritten with the newest result and ack_valid stays high.
- Without the macro: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Bytes A5,00,80,80 (80^00=80) -> duty_r=0x80, cfg_valid one pulse, duty_g/b=0, err_count=0.
- Bytes A5,03,40,43 -> duty_r=duty_g=duty_b=0x40, single cfg_valid.
- Bytes A5,01,10,00 (bad checksum) -> frame_err pulse, err_count=1, duties unchanged. Then 33,A5,02,20,22 -> byte 33 ignored, duty_b=0x20.
- Bytes A5,05,11,14 (addr 5 with valid checksum) -> frame_err, err_count increments.
- A5,02, then silence for TIMEOUT_CYCLES (set to 100) -> frame_err at cycle 99 after the last strobe, state IDLE. Repeat with the third byte arriving exactly at cycle 99 -> no timeout.
- rx_done held high for 16 cycles per byte -> exactly one byte_stb per byte. Then 300 bad frames -> err_count=255. Then assert rst_n=0 mid-frame -> all outputs reset. With PARSER_ACK_EN and ack_ready held low across two frames -> ack_data shows the latest result (06 or 15) until ack_ready goes high.
